// File: rtl/vect_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vect_pkg
// Description : Shared types and constants for the vector load/store slice.
//               Holds the memory-port arbiter state encoding and the AHB
//               response / transfer-size encodings used on the data port.
// Revision    : 1.0 - initial release
// ============================================================================
package vect_pkg;

  // Memory-port arbiter ownership states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;

  // AHB slave response encodings.
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Transfer size driven toward the slave when no master owns the port.
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

endpackage : vect_pkg
`default_nettype wire

// File: rtl/vlsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_mem_arbiter
// Description : Two-master arbiter sharing one AHB-style data port between
//               the scalar load/store path (master 0) and the vector
//               load/store unit (master 1). Ownership is registered and only
//               changes on beat boundaries (or when the owner stops
//               requesting). A per-grant beat counter caps how many
//               consecutive beats one master may complete while the other
//               waits; the vector unit may suppress that cap with m1_lock_i.
//               Master 0 wins simultaneous requests from idle.
//
// Ports       : clk_i, rst_i              clock, synchronous active-high reset
//               m{0,1}_req_i              transfer request, held until beat done
//               m{0,1}_haddr_i/hwrite_i/hsize_i/hwdata_i  transfer attributes
//               m1_lock_i                 vector unit asks for unbroken access
//               m{0,1}_hready_o/hresp_o   beat completion / response per master
//               hrdata_o                  slave read data, broadcast
//               hsel_o, haddr_o, hwrite_o, hsize_o, hwdata_o  toward slave
//               hrdata_i, hready_i, hresp_i                   from slave
//               grant_o                   one-hot current owner, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module vlsu_mem_arbiter
  import vect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0: scalar core
  input  logic                  m0_req_i,
  input  logic [DATA_WIDTH-1:0] m0_haddr_i,
  input  logic                  m0_hwrite_i,
  input  logic [2:0]            m0_hsize_i,
  input  logic [DATA_WIDTH-1:0] m0_hwdata_i,
  output logic                  m0_hready_o,
  output logic [1:0]            m0_hresp_o,
  // master 1: vector load/store unit
  input  logic                  m1_req_i,
  input  logic [DATA_WIDTH-1:0] m1_haddr_i,
  input  logic                  m1_hwrite_i,
  input  logic [2:0]            m1_hsize_i,
  input  logic [DATA_WIDTH-1:0] m1_hwdata_i,
  input  logic                  m1_lock_i,
  output logic                  m1_hready_o,
  output logic [1:0]            m1_hresp_o,
  // shared read data
  output logic [DATA_WIDTH-1:0] hrdata_o,
  // toward the slave
  output logic                  hsel_o,
  output logic [DATA_WIDTH-1:0] haddr_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  // from the slave
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  // debug / performance
  output logic [1:0]            grant_o
);

  localparam int unsigned      CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic cur_req;     // request of the current owner
  logic oth_req;     // request of the other master
  logic beat_done;   // owner's beat completes this cycle
  logic lock_active; // fairness cap suppressed for this owner
  logic limit_hit;   // this completion exhausts the owner's burst allowance

  // --------------------------------------------------------------------------
  // Next-state and beat counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cur_req     = 1'b0;
    oth_req     = 1'b0;

    unique case (state_q)
      ARB_M0: begin
        cur_req = m0_req_i;
        oth_req = m1_req_i;
      end
      ARB_M1: begin
        cur_req = m1_req_i;
        oth_req = m0_req_i;
      end
      default: begin
        cur_req = 1'b0;
        oth_req = 1'b0;
      end
    endcase

    beat_done   = (state_q != ARB_IDLE) && cur_req && hready_i;
    lock_active = (state_q == ARB_M1) && m1_lock_i;
    // '>=' rather than '==': after a locked run the counter sits saturated at
    // MAX_BURST, and the cap must still bite once the lock is released.
    limit_hit   = beat_done && (beat_cnt_q >= CNT_LIMIT) && !lock_active;

    unique case (state_q)
      ARB_IDLE: begin
        if (m0_req_i) begin
          state_d = ARB_M0;
        end else if (m1_req_i) begin
          state_d = ARB_M1;
        end
      end
      ARB_M0, ARB_M1: begin
        // Ownership is only reconsidered on a beat boundary or when the
        // owner has nothing in flight.
        if (beat_done || !cur_req) begin
          if (oth_req && (!cur_req || limit_hit)) begin
            state_d = (state_q == ARB_M0) ? ARB_M1 : ARB_M0;
          end else if (!cur_req) begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if ((state_q == ARB_IDLE) || (state_d != state_q)) begin
      beat_cnt_d = '0;
    end else if (beat_done && (beat_cnt_q < CNT_SAT)) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath mux and per-master responses, all steered by the registered
  // owner so a request can never reach the slave in the cycle it is raised.
  // --------------------------------------------------------------------------
  always_comb begin
    hsel_o      = 1'b0;
    haddr_o     = '0;
    hwrite_o    = 1'b0;
    hsize_o     = HSIZE_WORD;
    hwdata_o    = '0;
    m0_hready_o = 1'b0;
    m0_hresp_o  = HRESP_OKAY;
    m1_hready_o = 1'b0;
    m1_hresp_o  = HRESP_OKAY;
    grant_o     = 2'b00;

    unique case (state_q)
      ARB_M0: begin
        hsel_o      = m0_req_i;
        haddr_o     = m0_haddr_i;
        hwrite_o    = m0_hwrite_i;
        hsize_o     = m0_hsize_i;
        hwdata_o    = m0_hwdata_i;
        m0_hready_o = m0_req_i && hready_i;
        m0_hresp_o  = m0_req_i ? hresp_i : HRESP_OKAY;
        grant_o     = 2'b01;
      end
      ARB_M1: begin
        hsel_o      = m1_req_i;
        haddr_o     = m1_haddr_i;
        hwrite_o    = m1_hwrite_i;
        hsize_o     = m1_hsize_i;
        hwdata_o    = m1_hwdata_i;
        m1_hready_o = m1_req_i && hready_i;
        m1_hresp_o  = m1_req_i ? hresp_i : HRESP_OKAY;
        grant_o     = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own hready.
  assign hrdata_o = hrdata_i;

endmodule : vlsu_mem_arbiter
`default_nettype wire

// File: tb/tb_vlsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vlsu_mem_arbiter
// Description : Self-checking bench for vlsu_mem_arbiter. Two master agents
//               work through queues of beats, a slave agent inserts wait
//               states and error responses, and an ownership model predicts
//               the port owner and every slave-side and master-side output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vlsu_mem_arbiter;
  import vect_pkg::*;

  localparam int MB = 4;

  logic        clk, rst_i;
  logic        m0_req_i, m0_hwrite_i, m0_hready_o;
  logic [31:0] m0_haddr_i, m0_hwdata_i;
  logic [2:0]  m0_hsize_i;
  logic [1:0]  m0_hresp_o;
  logic        m1_req_i, m1_hwrite_i, m1_lock_i, m1_hready_o;
  logic [31:0] m1_haddr_i, m1_hwdata_i;
  logic [2:0]  m1_hsize_i;
  logic [1:0]  m1_hresp_o;
  logic [31:0] hrdata_o, haddr_o, hwdata_o, hrdata_i;
  logic        hsel_o, hwrite_o, hready_i;
  logic [2:0]  hsize_o;
  logic [1:0]  hresp_i, grant_o;

  vlsu_mem_arbiter #(.DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_haddr_i(m0_haddr_i), .m0_hwrite_i(m0_hwrite_i),
    .m0_hsize_i(m0_hsize_i), .m0_hwdata_i(m0_hwdata_i),
    .m0_hready_o(m0_hready_o), .m0_hresp_o(m0_hresp_o),
    .m1_req_i(m1_req_i), .m1_haddr_i(m1_haddr_i), .m1_hwrite_i(m1_hwrite_i),
    .m1_hsize_i(m1_hsize_i), .m1_hwdata_i(m1_hwdata_i), .m1_lock_i(m1_lock_i),
    .m1_hready_o(m1_hready_o), .m1_hresp_o(m1_hresp_o),
    .hrdata_o(hrdata_o), .hsel_o(hsel_o), .haddr_o(haddr_o),
    .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // agents
  beat_t q0[$], q1[$];
  int    gap0, gap1, gcfg0, gcfg1, start0, start1, cyc;
  bit    rand_gap;
  int    stall_pct, err_pct, lock_mode;
  logic  hr_plan[$];
  int    order[$];
  logic  s_h0, s_h1;

  // ownership model: owner 0 = nobody, 1 = master 0, 2 = master 1;
  // run = beats the owner has completed since it took the port
  int          own, run, nxt_own, nxt_run;
  logic        exp_hsel, exp_h0, exp_h1, exp_wr;
  logic [1:0]  exp_grant, exp_r0, exp_r1;
  logic [31:0] exp_addr, exp_wdata;
  logic [2:0]  exp_size;

  function automatic beat_t rand_beat();
    beat_t b;
    b.addr = $urandom;
    b.wr   = 1'($urandom_range(1));
    b.size = 3'($urandom_range(7));
    b.data = $urandom;
    return b;
  endfunction

  function automatic beat_t mk_beat(logic [31:0] a, logic w, logic [31:0] d);
    beat_t b;
    b.addr = a; b.wr = w; b.size = 3'b010; b.data = d;
    return b;
  endfunction

  // Drive both masters and the slave for this cycle and predict the outputs.
  task automatic drive();
    beat_t b0, b1;
    logic  r0, r1, done, me, other, lim;
    r0 = (q0.size() > 0) && (gap0 == 0) && (cyc >= start0);
    r1 = (q1.size() > 0) && (gap1 == 0) && (cyc >= start1);
    b0 = (q0.size() > 0) ? q0[0] : rand_beat();
    b1 = (q1.size() > 0) ? q1[0] : rand_beat();
    m0_req_i = r0; m0_haddr_i = b0.addr; m0_hwrite_i = b0.wr;
    m0_hsize_i = b0.size; m0_hwdata_i = b0.data;
    m1_req_i = r1; m1_haddr_i = b1.addr; m1_hwrite_i = b1.wr;
    m1_hsize_i = b1.size; m1_hwdata_i = b1.data;
    if (hr_plan.size() > 0) hready_i = hr_plan.pop_front();
    else hready_i = (int'($urandom_range(99)) >= stall_pct);
    hresp_i  = (int'($urandom_range(99)) < err_pct) ? HRESP_ERROR : HRESP_OKAY;
    hrdata_i = $urandom;
    if (lock_mode == 2) begin
      if ($urandom_range(15) == 0) m1_lock_i = ~m1_lock_i;
    end else begin
      m1_lock_i = (lock_mode == 1);
    end

    exp_hsel = 1'b0; exp_grant = 2'b00; exp_addr = '0; exp_wr = 1'b0;
    exp_size = 3'b010; exp_wdata = '0; exp_h0 = 1'b0; exp_h1 = 1'b0;
    exp_r0 = 2'b00; exp_r1 = 2'b00;
    if (own == 1) begin
      exp_grant = 2'b01; exp_hsel = r0; exp_addr = b0.addr; exp_wr = b0.wr;
      exp_size = b0.size; exp_wdata = b0.data; exp_h0 = r0 && hready_i;
      exp_r0 = r0 ? hresp_i : 2'b00;
    end else if (own == 2) begin
      exp_grant = 2'b10; exp_hsel = r1; exp_addr = b1.addr; exp_wr = b1.wr;
      exp_size = b1.size; exp_wdata = b1.data; exp_h1 = r1 && hready_i;
      exp_r1 = r1 ? hresp_i : 2'b00;
    end

    done  = exp_hsel && hready_i;
    me    = (own == 1) ? r0 : r1;
    other = (own == 1) ? r1 : r0;
    nxt_own = own;
    if (own == 0) begin
      nxt_own = r0 ? 1 : (r1 ? 2 : 0);
    end else if (done || !me) begin
      lim = done && (run + 1 >= MB) && !(own == 2 && m1_lock_i);
      if (other && (!me || lim)) nxt_own = 3 - own;
      else if (!me) nxt_own = 0;
    end
    if (nxt_own != own || own == 0) nxt_run = 0;
    else if (done) nxt_run = run + 1;
    else nxt_run = run;
  endtask

  // Called at the negative edge: sample completions, cross the clock edge.
  task automatic finish_cycle();
    s_h0 = m0_hready_o;
    s_h1 = m1_hready_o;
    @(posedge clk);
    if (rst_i) begin own = 0; run = 0; end
    else begin own = nxt_own; run = nxt_run; end
    if (s_h0 && q0.size() > 0) begin
      q0.delete(0); order.push_back(0);
      gap0 = rand_gap ? int'($urandom_range(2)) : gcfg0;
    end else if (gap0 > 0) gap0--;
    if (s_h1 && q1.size() > 0) begin
      q1.delete(0); order.push_back(1);
      gap1 = rand_gap ? int'($urandom_range(2)) : gcfg1;
    end else if (gap1 > 0) gap1--;
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    m0_req_i = 0; m1_req_i = 0; m1_lock_i = 0; hready_i = 1; hresp_i = 0;
    m0_haddr_i = 0; m0_hwrite_i = 0; m0_hsize_i = 0; m0_hwdata_i = 0;
    m1_haddr_i = 0; m1_hwrite_i = 0; m1_hsize_i = 0; m1_hwdata_i = 0;
    hrdata_i = 0;
    q0.delete(); q1.delete(); order.delete(); hr_plan.delete();
    gap0 = 0; gap1 = 0; gcfg0 = 0; gcfg1 = 0; start0 = 0; start1 = 0;
    rand_gap = 0; stall_pct = 0; err_pct = 0; lock_mode = 0;
    @(posedge clk); @(posedge clk);
    #1;
    rst_i = 1'b0; own = 0; run = 0; cyc = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    rst_i = 1'b1;
    m0_req_i = 1; m1_req_i = 1; m0_haddr_i = 32'hAAAA_0000; m0_hwrite_i = 1;
    m0_hwdata_i = 32'h1234_5678; m0_hsize_i = 3'b001; hresp_i = HRESP_ERROR;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (hsel_o !== 1'b0) begin errors++; $display("FAIL reset_hsel got=%b exp=0", hsel_o); end
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    checks++; if (haddr_o !== 32'h0 || hwrite_o !== 1'b0 || hwdata_o !== 32'h0)
      begin errors++; $display("FAIL reset_bus got addr=%h wr=%b wdata=%h exp 0/0/0", haddr_o, hwrite_o, hwdata_o); end
    checks++; if (hsize_o !== 3'b010) begin errors++; $display("FAIL reset_hsize got=%b exp=010", hsize_o); end
    checks++; if ({m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o} !== 6'b0)
      begin errors++; $display("FAIL reset_resp got rdy=%b%b resp=%b/%b exp all 0", m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o); end
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single_m0();
    reset_dut();
    q0.push_back(mk_beat(32'h100, 1'b0, 32'h0));
    for (int c = 0; c < 4; c++) begin
      drive();
      @(negedge clk);
      case (c)
        0: begin
          checks++; if (hsel_o !== 1'b0 || grant_o !== 2'b00)
            begin errors++; $display("FAIL single_latency got hsel=%b grant=%b exp 0/00", hsel_o, grant_o); end
        end
        1: begin
          checks++; if (hsel_o !== 1'b1 || haddr_o !== 32'h100)
            begin errors++; $display("FAIL single_beat got hsel=%b addr=%h exp 1/100", hsel_o, haddr_o); end
          checks++; if (m0_hready_o !== 1'b1 || grant_o !== 2'b01)
            begin errors++; $display("FAIL single_ready got rdy=%b grant=%b exp 1/01", m0_hready_o, grant_o); end
        end
        2: begin
          checks++; if (hsel_o !== 1'b0 || grant_o !== 2'b01)
            begin errors++; $display("FAIL single_release got hsel=%b grant=%b exp 0/01", hsel_o, grant_o); end
        end
        default: begin
          checks++; if (grant_o !== 2'b00)
            begin errors++; $display("FAIL single_idle got grant=%b exp=00", grant_o); end
        end
      endcase
      finish_cycle();
    end
  endtask

  task automatic test_simultaneous();
    int          svc_cyc[$];
    logic [31:0] svc_addr[$];
    reset_dut();
    q0.push_back(mk_beat(32'h10, 1'b0, 32'h0));
    q1.push_back(mk_beat(32'h20, 1'b0, 32'h0));
    for (int c = 0; c < 8; c++) begin
      drive();
      @(negedge clk);
      if (hsel_o === 1'b1) begin svc_cyc.push_back(c); svc_addr.push_back(haddr_o); end
      finish_cycle();
    end
    checks++; if (svc_cyc.size() != 2)
      begin errors++; $display("FAIL simul_count got=%0d exp=2", svc_cyc.size()); end
    else begin
      checks++; if (svc_addr[0] !== 32'h10 || svc_cyc[0] != 1)
        begin errors++; $display("FAIL simul_first got addr=%h cyc=%0d exp 10/1", svc_addr[0], svc_cyc[0]); end
      checks++; if (svc_addr[1] !== 32'h20 || svc_cyc[1] != 3)
        begin errors++; $display("FAIL simul_second got addr=%h cyc=%0d exp 20/3", svc_addr[1], svc_cyc[1]); end
    end
  endtask

  task automatic test_fairness(input bit lock);
    int exp_order[$];
    int bad;
    reset_dut();
    lock_mode = lock ? 1 : 0;
    for (int i = 0; i < 16; i++) q1.push_back(mk_beat(32'h1000 + 4 * i, 1'b0, 32'h0));
    for (int i = 0; i < 4; i++)  q0.push_back(mk_beat(32'h2000 + 4 * i, 1'b1, 32'h5A00 + i));
    start0 = 2; gcfg0 = 1;
    if (lock) begin
      for (int i = 0; i < 16; i++) exp_order.push_back(1);
      for (int i = 0; i < 4; i++)  exp_order.push_back(0);
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < MB; i++) exp_order.push_back(1);
        exp_order.push_back(0);
      end
    end
    for (int c = 0; c < 200 && (q0.size() > 0 || q1.size() > 0); c++) begin
      drive();
      @(negedge clk);
      finish_cycle();
    end
    checks++; if (q0.size() != 0 || q1.size() != 0)
      begin errors++; $display("FAIL fair_drain lock=%0d left m0=%0d m1=%0d exp 0/0", lock, q0.size(), q1.size()); end
    bad = -1;
    for (int i = 0; i < exp_order.size(); i++)
      if (bad < 0 && (i >= order.size() || order[i] != exp_order[i])) bad = i;
    checks++; if (bad >= 0 || order.size() != exp_order.size())
      begin errors++; $display("FAIL fair_order lock=%0d first_diff=%0d got_len=%0d exp_len=%0d", lock, bad, order.size(), exp_order.size()); end
  endtask

  task automatic test_stall_switch();
    reset_dut();
    q1.push_back(mk_beat(32'h40, 1'b1, 32'hDEAD_BEEF));
    q0.push_back(mk_beat(32'h80, 1'b0, 32'h0));
    start0 = 2;
    hr_plan = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      drive();
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++; if (grant_o !== 2'b10 || hsel_o !== 1'b1 || m1_hready_o !== 1'b0 || m0_hready_o !== 1'b0)
          begin errors++; $display("FAIL stall_hold c=%0d got grant=%b hsel=%b rdy=%b%b exp 10/1/00", c, grant_o, hsel_o, m1_hready_o, m0_hready_o); end
        checks++; if (hwrite_o !== 1'b1 || hwdata_o !== 32'hDEAD_BEEF || haddr_o !== 32'h40)
          begin errors++; $display("FAIL stall_bus c=%0d got wr=%b wdata=%h addr=%h", c, hwrite_o, hwdata_o, haddr_o); end
      end else if (c == 4) begin
        checks++; if (m1_hready_o !== 1'b1 || grant_o !== 2'b10)
          begin errors++; $display("FAIL stall_pulse got rdy=%b grant=%b exp 1/10", m1_hready_o, grant_o); end
      end else if (c == 5) begin
        checks++; if (hsel_o !== 1'b0 || m0_hready_o !== 1'b0)
          begin errors++; $display("FAIL stall_turn got hsel=%b m0rdy=%b exp 0/0", hsel_o, m0_hready_o); end
      end else if (c == 6) begin
        checks++; if (grant_o !== 2'b01 || hsel_o !== 1'b1 || haddr_o !== 32'h80 || m0_hready_o !== 1'b1)
          begin errors++; $display("FAIL stall_m0 got grant=%b hsel=%b addr=%h rdy=%b exp 01/1/80/1", grant_o, hsel_o, haddr_o, m0_hready_o); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_midbeat();
    reset_dut();
    q1.push_back(mk_beat(32'h44, 1'b1, 32'hCAFE_F00D));
    hr_plan = '{1'b1, 1'b0};
    drive(); @(negedge clk); finish_cycle();
    drive(); @(negedge clk);
    checks++; if (hsel_o !== 1'b1 || grant_o !== 2'b10)
      begin errors++; $display("FAIL midbeat_pre got hsel=%b grant=%b exp 1/10", hsel_o, grant_o); end
    rst_i = 1'b1;
    finish_cycle();
    rst_i = 1'b0;
    err_pct = 100;
    drive(); @(negedge clk);
    checks++; if (hsel_o !== 1'b0 || grant_o !== 2'b00)
      begin errors++; $display("FAIL midbeat_abort got hsel=%b grant=%b exp 0/00", hsel_o, grant_o); end
    checks++; if (haddr_o !== 32'h0 || hwrite_o !== 1'b0 || hwdata_o !== 32'h0 || hsize_o !== 3'b010)
      begin errors++; $display("FAIL midbeat_bus got addr=%h wr=%b wdata=%h size=%b", haddr_o, hwrite_o, hwdata_o, hsize_o); end
    checks++; if ({m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o} !== 6'b0)
      begin errors++; $display("FAIL midbeat_resp got rdy=%b%b resp=%b/%b exp 0", m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o); end
    finish_cycle();
  endtask

  task automatic test_random_traffic(input int lmode, input int ncyc);
    reset_dut();
    rand_gap = 1; stall_pct = 30; err_pct = 10; lock_mode = lmode;
    for (int c = 0; c < ncyc; c++) begin
      if (q0.size() == 0 && $urandom_range(3) == 0)
        for (int i = 0; i <= int'($urandom_range(3)); i++) q0.push_back(rand_beat());
      if (q1.size() == 0 && $urandom_range(2) == 0)
        for (int i = 0; i <= int'($urandom_range(9)); i++) q1.push_back(rand_beat());
      drive();
      @(negedge clk);
      checks++; if (grant_o !== exp_grant || hsel_o !== exp_hsel)
        begin errors++; $display("FAIL rnd_grant cyc=%0d got grant=%b hsel=%b exp %b/%b", c, grant_o, hsel_o, exp_grant, exp_hsel); end
      checks++; if (haddr_o !== exp_addr || hwrite_o !== exp_wr || hsize_o !== exp_size || hwdata_o !== exp_wdata)
        begin errors++; $display("FAIL rnd_bus cyc=%0d got %h/%b/%b/%h exp %h/%b/%b/%h", c, haddr_o, hwrite_o, hsize_o, hwdata_o, exp_addr, exp_wr, exp_size, exp_wdata); end
      checks++; if (m0_hready_o !== exp_h0 || m1_hready_o !== exp_h1)
        begin errors++; $display("FAIL rnd_ready cyc=%0d got %b%b exp %b%b", c, m0_hready_o, m1_hready_o, exp_h0, exp_h1); end
      checks++; if (m0_hresp_o !== exp_r0 || m1_hresp_o !== exp_r1)
        begin errors++; $display("FAIL rnd_resp cyc=%0d got %b/%b exp %b/%b", c, m0_hresp_o, m1_hresp_o, exp_r0, exp_r1); end
      checks++; if (hrdata_o !== hrdata_i)
        begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", c, hrdata_o, hrdata_i); end
      finish_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_simultaneous();
    test_fairness(1'b0);
    test_fairness(1'b1);
    test_stall_switch();
    test_reset_midbeat();
    test_random_traffic(0, 3000);
    test_random_traffic(2, 3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vlsu_mem_arbiter
`default_nettype wire
